tmr_command_voter: RTL and testbench

//  Upstream neighbour of the PMU. Collects one command word from each of three

---
 rtl/tmr_command_voter.sv | 125 ++++++++++++
 tb/tb_tmr_command_voter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tmr_command_voter.sv
// tmr_command_voter: majority-votes one command word from each of three redundant channels; optional VOTER_PARITY_EN adds per-channel even parity
module tmr_command_voter #(
    parameter int CMD_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMER_WIDTH    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3*CMD_WIDTH-1:0] ch_data,
    input  logic [2:0]             ch_valid,
`ifdef VOTER_PARITY_EN
    input  logic [2:0]             ch_parity,
`endif
    output logic [2:0]             ch_ready,
    output logic [CMD_WIDTH-1:0]   cmd_out,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   cmd_error,
    output logic [2:0]             command_arrive,
    output logic [2:0]             command_arrive_discrepancy
);
    typedef enum logic [1:0] {IDLE, COLLECT, VOTE, OUTPUT} state_t;
    state_t state, state_nx;
    logic [CMD_WIDTH-1:0]   word [3];
    logic [CMD_WIDTH-1:0]   maj;
    logic [2:0]             cap, bad, bad_in, xfer, live, disc_nx;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   m01, m02, m12, has_maj, timeout;

    assign ch_ready = (state == IDLE) ? 3'b111 : (state == COLLECT) ? ~cap : 3'b000;
    assign xfer     = ch_valid & ch_ready;
    assign timeout  = timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

`ifdef VOTER_PARITY_EN
    // flag incoming words whose even parity does not check
    always_comb begin
        bad_in = '0;
        for (int i = 0; i < 3; i++)
            bad_in[i] = ^{ch_data[i*CMD_WIDTH +: CMD_WIDTH], ch_parity[i]};
    end
`else
    assign bad_in = '0;
`endif

    // majority over captured, parity-clean words and per-channel discrepancy
    always_comb begin
        live    = cap & ~bad;
        m01     = live[0] & live[1] & (word[0] == word[1]);
        m02     = live[0] & live[2] & (word[0] == word[2]);
        m12     = live[1] & live[2] & (word[1] == word[2]);
        has_maj = m01 | m02 | m12;
        maj     = (m01 | m02) ? word[0] : word[1];
        disc_nx = '1;
        for (int i = 0; i < 3; i++)
            disc_nx[i] = !has_maj || !live[i] || (word[i] != maj);
    end

    // next-state decision
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (&xfer) ? VOTE : (|xfer) ? COLLECT : IDLE;
            COLLECT: state_nx = (&(cap | xfer) || timeout) ? VOTE : COLLECT;
            VOTE:    state_nx = has_maj ? OUTPUT : IDLE;
            OUTPUT:  state_nx = cmd_ready ? IDLE : OUTPUT;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // capture, timer and registered vote outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cap                        <= '0;
            bad                        <= '0;
            timer                      <= '0;
            cmd_out                    <= '0;
            cmd_valid                  <= 1'b0;
            cmd_error                  <= 1'b0;
            command_arrive             <= '0;
            command_arrive_discrepancy <= '0;
            for (int i = 0; i < 3; i++) word[i] <= '0;
        end else begin
            cmd_error                  <= 1'b0;
            command_arrive             <= '0;
            command_arrive_discrepancy <= '0;
            for (int i = 0; i < 3; i++)
                if (xfer[i]) begin
                    word[i] <= ch_data[i*CMD_WIDTH +: CMD_WIDTH];
                    bad[i]  <= bad_in[i];
                end
            case (state)
                IDLE: begin
                    cap   <= xfer;
                    timer <= '0;
                end
                COLLECT: begin
                    cap   <= cap | xfer;
                    timer <= timer + 1'b1;
                end
                VOTE: begin
                    command_arrive             <= cap;
                    command_arrive_discrepancy <= disc_nx;
                    if (has_maj) begin
                        cmd_out   <= maj;
                        cmd_valid <= 1'b1;
                    end else begin
                        cmd_error <= 1'b1;
                        cap       <= '0;
                    end
                end
                OUTPUT: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        cap       <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tmr_command_voter.sv
// tb_tmr_command_voter: directed checks of voting, timeout, no-majority, backpressure and reset
module tb_tmr_command_voter;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] ch_data;
    logic [2:0]  ch_valid;
    logic [2:0]  ch_ready;
    logic [7:0]  cmd_out;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_error;
    logic [2:0]  command_arrive;
    logic [2:0]  command_arrive_discrepancy;
    int          errors = 0;
    int          checks = 0;
`ifdef VOTER_PARITY_EN
    logic [2:0]  ch_parity;
    assign ch_parity = {^ch_data[23:16], ^ch_data[15:8], ^ch_data[7:0]};
`endif

    tmr_command_voter #(.CMD_WIDTH(8), .TIMEOUT_CYCLES(4), .TIMER_WIDTH(3)) dut (
        .clk(clk),
        .rst(rst),
        .ch_data(ch_data),
        .ch_valid(ch_valid),
`ifdef VOTER_PARITY_EN
        .ch_parity(ch_parity),
`endif
        .ch_ready(ch_ready),
        .cmd_out(cmd_out),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_error(cmd_error),
        .command_arrive(command_arrive),
        .command_arrive_discrepancy(command_arrive_discrepancy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic handshake(input string tag);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk({tag, "_valid_drop"}, cmd_valid, 0);
        chk({tag, "_ready_idle"}, ch_ready, 3'b111);
    endtask

    initial begin
        rst = 1'b1; ch_data = '0; ch_valid = '0; cmd_ready = 1'b0;
        step();
        step();
        chk("rst_ch_ready", ch_ready, 3'b111);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_out", cmd_out, 0);
        chk("rst_cmd_error", cmd_error, 0);
        chk("rst_arrive", command_arrive, 0);
        chk("rst_disc", command_arrive_discrepancy, 0);
        rst = 1'b0;
        step();

        ch_data = {8'hA5, 8'hA5, 8'hA5}; ch_valid = 3'b111;
        step();
        ch_valid = 3'b000;
        chk("t1_vote_ready", ch_ready, 3'b000);
        chk("t1_vote_valid", cmd_valid, 0);
        step();
        chk("t1_cmd_out", cmd_out, 8'hA5);
        chk("t1_cmd_valid", cmd_valid, 1);
        chk("t1_arrive", command_arrive, 3'b111);
        chk("t1_disc", command_arrive_discrepancy, 3'b000);
        step();
        chk("t1_arrive_pulse", command_arrive, 3'b000);
        chk("t1_valid_hold", cmd_valid, 1);
        handshake("t1");

        ch_data = {8'h3C, 8'h3D, 8'h3C}; ch_valid = 3'b111;
        step();
        ch_valid = 3'b000;
        step();
        chk("t2_cmd_out", cmd_out, 8'h3C);
        chk("t2_cmd_valid", cmd_valid, 1);
        chk("t2_arrive", command_arrive, 3'b111);
        chk("t2_disc", command_arrive_discrepancy, 3'b010);
        handshake("t2");

        ch_data = {8'h00, 8'h11, 8'h11}; ch_valid = 3'b011;
        step();
        ch_valid = 3'b000;
        chk("t3_collect_ready", ch_ready, 3'b100);
        step();
        step();
        step();
        chk("t3_still_collect", ch_ready, 3'b100);
        step();
        chk("t3_vote_ready", ch_ready, 3'b000);
        chk("t3_no_early_valid", cmd_valid, 0);
        step();
        chk("t3_cmd_out", cmd_out, 8'h11);
        chk("t3_cmd_valid", cmd_valid, 1);
        chk("t3_arrive", command_arrive, 3'b011);
        chk("t3_disc", command_arrive_discrepancy, 3'b100);
        handshake("t3");

        ch_data = {8'h03, 8'h02, 8'h01}; ch_valid = 3'b111;
        step();
        ch_valid = 3'b000;
        step();
        chk("t4_error", cmd_error, 1);
        chk("t4_disc", command_arrive_discrepancy, 3'b111);
        chk("t4_arrive", command_arrive, 3'b111);
        chk("t4_no_valid", cmd_valid, 0);
        chk("t4_ready_idle", ch_ready, 3'b111);
        step();
        chk("t4_error_pulse", cmd_error, 0);
        chk("t4_disc_pulse", command_arrive_discrepancy, 3'b000);

        ch_data = {8'h5A, 8'h5A, 8'h5A}; ch_valid = 3'b111;
        step();
        ch_valid = 3'b000;
        step();
        chk("t5_cmd_valid", cmd_valid, 1);
        ch_data = {8'h77, 8'h77, 8'h77}; ch_valid = 3'b111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_hold_out", cmd_out, 8'h5A);
            chk("t5_hold_valid", cmd_valid, 1);
            chk("t5_hold_ready", ch_ready, 3'b000);
        end
        ch_valid = 3'b000;
        handshake("t5");
        chk("t5_no_arrive", command_arrive, 3'b000);

        ch_data = {8'h00, 8'h00, 8'h42}; ch_valid = 3'b001;
        step();
        ch_valid = 3'b000;
        step();
        chk("t6_collect_ready", ch_ready, 3'b110);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_ready", ch_ready, 3'b111);
        chk("t6_rst_valid", cmd_valid, 0);
        chk("t6_rst_arrive", command_arrive, 0);
        chk("t6_rst_disc", command_arrive_discrepancy, 0);
        chk("t6_rst_error", cmd_error, 0);
        for (int i = 0; i < 6; i++) step();
        chk("t6_no_late_pulse", command_arrive, 0);
        chk("t6_no_late_error", cmd_error, 0);
        ch_data = {8'h99, 8'h99, 8'h99}; ch_valid = 3'b111;
        step();
        ch_valid = 3'b000;
        step();
        chk("t6_cmd_out", cmd_out, 8'h99);
        chk("t6_cmd_valid", cmd_valid, 1);
        chk("t6_arrive", command_arrive, 3'b111);
        chk("t6_disc", command_arrive_discrepancy, 3'b000);
        handshake("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
